xbar_arbiter: RTL and testbench
===============================

# xbar_arbiter

Control and ordering side of the 2x2 memory crossbar. It sits between two requesters (0 = instruction fetch, 1 = load/store) and two targets (memory banks 0/1). Each cycle it decides which requester reaches which target and drives the swap control for the 2x2 data crossbar. It arbitrates round-robin when both requesters want the same bank, tracks one outstanding transaction per target, and routes each response back to the requester that issued it.

## Interface
- `ADDR_W`, default 32: request address width.
- `DATA_W`, default 32: write and read data width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  [1:0]  per-requester request valid.
- `req_ready`  out  [1:0]  per-requester request accepted.
- `req_tgt`  in  [1:0]  target bank selected by requester i.
- `req_we`  in  [1:0]  write enable.
- `req_addr`  in  [1:0][ADDR_W-1:0]  address.
- `req_wdata`  in  [1:0][DATA_W-1:0]  write data.
- `resp_valid`  out  [1:0]  response to requester i.
- `resp_rdata`  out  [1:0][DATA_W-1:0]  read data to requester i.
- `tgt_valid`  out  [1:0]  request valid to bank j.
- `tgt_ready`  in  [1:0]  bank j accepts.
- `tgt_we`, `tgt_addr`, `tgt_wdata`  out  per-bank copies of the granted request fields.
- `tgt_resp_valid`  in  [1:0]  bank j response.
- `tgt_resp_rdata`  in  [1:0][DATA_W-1:0]  bank j read data.
- `xbar_swap`  out  1  high when the granted paths cross (req0→bank1 or req1→bank0).

## Operation
- Per-target state: IDLE or BUSY, plus `owner` (1 bit) and `rr_ptr` (1 bit, the requester that has priority next).
- Per-requester state: IDLE or WAIT. A requester in WAIT has `req_ready=0` and is not considered for arbitration.
- **Candidates:** requester i is a candidate for bank j when it is IDLE, `req_valid[i]=1` and `req_tgt[i]=j`.
- **Arbitration per bank j (IDLE only):**
  - One candidate: that candidate is granted.
  - Two candidates: `rr_ptr` wins.
  - BUSY bank: no grant, `tgt_valid[j]=0`.
- **Request forwarding:** for a granted bank, `tgt_valid[j]=1` and `tgt_we`/`tgt_addr`/`tgt_wdata` come from the winner. For an ungranted bank, these fields are 0.
- **Accept handshake:** the request is accepted when `tgt_valid[j] & tgt_ready[j]`. The same handshake drives `req_ready[winner]=1`; the loser sees `req_ready=0` and must hold its request stable.
- **On accept:**
  - bank j → BUSY, `owner` ← winner.
  - winner → WAIT.
  - `rr_ptr` ← ~winner, updated only when a grant is accepted.
- **Response:** `resp_valid[owner_j] = tgt_resp_valid[j] & BUSY_j`, with `resp_rdata` taken from that bank. Responses have no backpressure.
- **On response:** bank j → IDLE and the owning requester → IDLE, both at the clock edge.
- **Writes also complete by response:** every request, including writes, gets exactly one `tgt_resp_valid`.
- **Stray response** (`tgt_resp_valid` while the bank is IDLE): ignored, no output. The bench treats it as a protocol error.
- **Swap control:** `xbar_swap = (grant0 & req_tgt[0]) | (grant1 & ~req_tgt[1])`. With no grant it is 0.

## Timing
- Request path is combinational: valid→grant→`tgt_valid` in the same cycle. The request and response paths have zero added latency.
- All state updates happen at the rising edge of `clk`.
- **Response and new request in the same cycle:**
  - Same bank: the bank becomes IDLE at that edge. The new request is granted no earlier than the following cycle (no bypass).
  - Same requester: that requester may issue its next request one cycle after its `resp_valid`.
- A response can arrive at the earliest one cycle after its accept.
- Minimum repeat rate per requester: one transaction every 2 cycles.
- **Reset (any time, including mid-transaction):** all banks IDLE, all requesters IDLE, owners 0, `rr_ptr`=0 (requester 0 favoured first).
  - In-flight transactions are dropped.
  - Responses arriving after reset are stray and ignored.
- **Output values during reset:** `req_ready`, `resp_valid`, `tgt_valid` and `xbar_swap` are 0; data outputs are 0.

## Structure
- `xbar_pkg`: `slot_state_e` {IDLE, BUSY}, `req_state_e` {IDLE, WAIT}, and the `NUM_PORTS=2` constant.
- Sub-module `xbar_arb_slot`, instantiated once per bank. It holds the state, `owner` and `rr_ptr`, and produces the grant vector.
- The top level does candidate decode, the field muxing, the response demux and `xbar_swap`.

## Test plan
- **Uncontended straight:** req0→bank0 and req1→bank1 in the same cycle, both `tgt_ready=1` → both accepted, `xbar_swap=0`. Responses `0xAAAA0000`/`0x5555` one cycle later reach requesters 0/1.
- **Crossed:** req0→bank1 and req1→bank0 → `xbar_swap=1`. `tgt_addr[1]` equals `req_addr[0]` (`0x100`). Responses return crossed.
- **Contention:** both requesters target bank0 for 4 transactions each → grants alternate 0,1,0,1. The loser holds with `req_ready=0`, and no request is lost.
- **Busy bank:** bank0 withholds its response for 5 cycles → `tgt_valid[0]=0` throughout. In the response cycle, req1 (→bank0) is not granted; it is granted the next cycle.
- **Backpressure:** `tgt_ready[1]=0` for 3 cycles → the request is held, no state change. Accepted on the 4th cycle.
- **Reset mid-transaction and stray response:** assert `rst_n`=0 while bank1 is BUSY, then deliver `tgt_resp_valid[1]` after reset → no `resp_valid`. The next contention is won by requester 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and constants for the 2x2 crossbar arbiter.
package xbar_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic {SLOT_IDLE = 1'b0, SLOT_BUSY = 1'b1} slot_state_e;
  typedef enum logic {REQ_IDLE = 1'b0, REQ_WAIT = 1'b1} req_state_e;

  // Pick the winning requester index from a candidate pair and the
  // round-robin pointer: a single candidate always wins, a tie goes to ptr.
  function automatic logic rr_pick(input logic [NUM_PORTS-1:0] cand, input logic ptr);
    logic pick;
    if (cand == 2'b11) pick = ptr;
    else               pick = cand[1];
    return pick;
  endfunction

endpackage

// File: rtl/xbar_arb_slot.sv
// Per-bank arbitration slot: holds IDLE/BUSY state, the owning requester
// and the round-robin pointer, and produces the one-hot grant vector.
module xbar_arb_slot
  import xbar_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] cand,
  input  logic                 tgt_ready,
  input  logic                 tgt_resp_valid,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 accept,
  output logic                 busy,
  output logic                 owner
);

  slot_state_e state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        rr_ptr_reg, rr_ptr_next;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= SLOT_IDLE;
      owner_reg  <= 1'b0;
      rr_ptr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Grant/accept decode and next-state; a busy bank never grants, and a
  // response frees the bank only at the edge (no same-cycle re-grant).
  always_comb begin
    logic winner;
    winner      = 1'b0;
    grant       = '0;
    accept      = 1'b0;
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      SLOT_IDLE: begin
        if (rst_n && (cand != '0)) begin
          winner = rr_pick(cand, rr_ptr_reg);
          grant  = winner ? 2'b10 : 2'b01;
          accept = tgt_ready;
          if (tgt_ready) begin
            state_next  = SLOT_BUSY;
            owner_next  = winner;
            rr_ptr_next = ~winner;
          end
        end
      end
      SLOT_BUSY: begin
        if (tgt_resp_valid) state_next = SLOT_IDLE;
      end
      default: state_next = SLOT_IDLE;
    endcase
  end

  assign busy  = (state_reg == SLOT_BUSY);
  assign owner = owner_reg;

endmodule

// File: rtl/xbar_arbiter.sv
// 2x2 crossbar control: candidate decode, per-bank arbitration slots,
// request field muxing, response routing and the data-path swap control.
module xbar_arbiter
  import xbar_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_tgt,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] resp_rdata,
  output logic [NUM_PORTS-1:0]             tgt_valid,
  input  logic [NUM_PORTS-1:0]             tgt_ready,
  output logic [NUM_PORTS-1:0]             tgt_we,
  output logic [NUM_PORTS-1:0][ADDR_W-1:0] tgt_addr,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] tgt_wdata,
  input  logic [NUM_PORTS-1:0]             tgt_resp_valid,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] tgt_resp_rdata,
  output logic                             xbar_swap
);

  req_state_e           req_state_reg  [NUM_PORTS];
  req_state_e           req_state_next [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_idle;
  logic [NUM_PORTS-1:0] cand  [NUM_PORTS];   // indexed [bank][requester]
  logic [NUM_PORTS-1:0] grant [NUM_PORTS];   // indexed [bank][requester]
  logic [NUM_PORTS-1:0] accept;
  logic [NUM_PORTS-1:0] busy;
  logic [NUM_PORTS-1:0] owner;
  logic [NUM_PORTS-1:0] resp_hit;

  genvar gi;

  // Bank side: one arbitration slot per bank plus forwarding of the winner.
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_bank
      assign cand[gi][0] = req_valid[0] & req_idle[0] & (req_tgt[0] == 1'(gi));
      assign cand[gi][1] = req_valid[1] & req_idle[1] & (req_tgt[1] == 1'(gi));

      xbar_arb_slot u_slot (
        .clk            (clk),
        .rst_n          (rst_n),
        .cand           (cand[gi]),
        .tgt_ready      (tgt_ready[gi]),
        .tgt_resp_valid (tgt_resp_valid[gi]),
        .grant          (grant[gi]),
        .accept         (accept[gi]),
        .busy           (busy[gi]),
        .owner          (owner[gi])
      );

      assign tgt_valid[gi] = |grant[gi];
      assign tgt_we[gi]    = tgt_valid[gi] ? req_we[grant[gi][1]]    : 1'b0;
      assign tgt_addr[gi]  = tgt_valid[gi] ? req_addr[grant[gi][1]]  : '0;
      assign tgt_wdata[gi] = tgt_valid[gi] ? req_wdata[grant[gi][1]] : '0;
      // Stray responses on an idle bank are dropped here.
      assign resp_hit[gi]  = tgt_resp_valid[gi] & busy[gi];
    end
  endgenerate

  // Requester side: handshake, response demux and WAIT tracking.
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_req
      logic hit0, hit1;
      assign hit0 = resp_hit[0] & (owner[0] == 1'(gi));
      assign hit1 = resp_hit[1] & (owner[1] == 1'(gi));

      assign req_idle[gi]   = (req_state_reg[gi] == REQ_IDLE);
      assign req_ready[gi]  = (grant[0][gi] & accept[0]) | (grant[1][gi] & accept[1]);
      assign resp_valid[gi] = hit0 | hit1;
      assign resp_rdata[gi] = hit0 ? tgt_resp_rdata[0] :
                              hit1 ? tgt_resp_rdata[1] : '0;

      // Next requester state: WAIT from accept until its response.
      always_comb begin
        req_state_next[gi] = req_state_reg[gi];
        case (req_state_reg[gi])
          REQ_IDLE: if (req_ready[gi])  req_state_next[gi] = REQ_WAIT;
          REQ_WAIT: if (resp_valid[gi]) req_state_next[gi] = REQ_IDLE;
          default:  req_state_next[gi] = REQ_IDLE;
        endcase
      end

      // Requester state register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_state_reg[gi] <= REQ_IDLE;
        else        req_state_reg[gi] <= req_state_next[gi];
      end
    end
  endgenerate

  // Paths cross when requester 0 is granted bank 1 or requester 1 bank 0.
  assign xbar_swap = grant[1][0] | grant[0][1];

endmodule

// File: tb/tb_xbar_arbiter.sv
// Directed scoreboard bench for xbar_arbiter: stimulus pushes expected
// accepts/responses, a negedge monitor pops and compares them.
module tb_xbar_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_tgt, req_we;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0]       resp_valid;
  logic [1:0][31:0] resp_rdata;
  logic [1:0]       tgt_valid, tgt_ready, tgt_we;
  logic [1:0][31:0] tgt_addr, tgt_wdata;
  logic [1:0]       tgt_resp_valid;
  logic [1:0][31:0] tgt_resp_rdata;
  logic             xbar_swap;

  typedef struct {
    logic        bank;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        swap;
  } acc_t;

  typedef struct {
    logic        req;
    logic [31:0] rdata;
  } resp_t;

  acc_t  exp_acc[$];
  resp_t exp_resp[$];
  int    vectors = 0;
  int    miscompares = 0;

  xbar_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_tgt        (req_tgt),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .tgt_valid      (tgt_valid),
    .tgt_ready      (tgt_ready),
    .tgt_we         (tgt_we),
    .tgt_addr       (tgt_addr),
    .tgt_wdata      (tgt_wdata),
    .tgt_resp_valid (tgt_resp_valid),
    .tgt_resp_rdata (tgt_resp_rdata),
    .xbar_swap      (xbar_swap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    req_valid      = '0;
    req_tgt        = '0;
    req_we         = '0;
    req_addr       = '0;
    req_wdata      = '0;
    tgt_ready      = '0;
    tgt_resp_valid = '0;
    tgt_resp_rdata = '0;
  endtask

  task automatic push_acc(input logic bank, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic swap);
    acc_t e;
    e.bank = bank; e.req = req; e.we = we; e.addr = addr; e.wdata = wdata; e.swap = swap;
    exp_acc.push_back(e);
  endtask

  task automatic push_resp(input logic req, input logic [31:0] rdata);
    resp_t e;
    e.req = req; e.rdata = rdata;
    exp_resp.push_back(e);
  endtask

  // Monitor: every accepted request and every response is popped and compared.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < 2; j++) begin
        if (tgt_valid[j] && tgt_ready[j]) begin
          vectors++;
          if (exp_acc.size() == 0) begin
            miscompares++;
            $display("FAIL acc_unexpected bank%0d: got addr %h want none", j, tgt_addr[j]);
          end else begin
            acc_t e;
            logic [66:0] got, want;
            e    = exp_acc.pop_front();
            got  = {j[0], req_ready[e.req], tgt_we[j], tgt_addr[j], tgt_wdata[j], xbar_swap};
            want = {e.bank, 1'b1, e.we, e.addr, e.wdata, e.swap};
            $display("acc bank%0d req%0d we=%0d addr=%h wdata=%h swap=%0d",
                     j, e.req, tgt_we[j], tgt_addr[j], tgt_wdata[j], xbar_swap);
            if (got !== want) begin
              miscompares++;
              $display("FAIL acc bank%0d: got %h want %h", j, got, want);
            end
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (resp_valid[i]) begin
          vectors++;
          if (exp_resp.size() == 0) begin
            miscompares++;
            $display("FAIL resp_unexpected req%0d: got %h want none", i, resp_rdata[i]);
          end else begin
            resp_t e;
            e = exp_resp.pop_front();
            $display("resp req%0d rdata=%h", i, resp_rdata[i]);
            if ({i[0], resp_rdata[i]} !== {e.req, e.rdata}) begin
              miscompares++;
              $display("FAIL resp req%0d: got %h want %h", i, {i[0], resp_rdata[i]}, {e.req, e.rdata});
            end
          end
        end
      end
    end
  end

  initial begin
    // Reset with live inputs: all control and data outputs must stay 0.
    idle();
    rst_n          = 1'b0;
    req_valid      = 2'b11;
    req_addr       = {32'h0000_0022, 32'h0000_0011};
    tgt_ready      = 2'b11;
    tgt_resp_valid = 2'b11;
    tick(); tick(); settle();
    chk("reset_ctrl", 64'({req_ready, resp_valid, tgt_valid, xbar_swap}), 64'd0);
    chk("reset_data", {tgt_addr[1], tgt_addr[0]}, 64'd0);
    rst_n = 1'b1;
    idle();
    tick();

    // Uncontended straight: req0->bank0, req1->bank1.
    req_valid = 2'b11; req_tgt = 2'b10; tgt_ready = 2'b11;
    req_addr  = {32'h0000_0020, 32'h0000_0010};
    push_acc(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    push_acc(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    settle();
    chk("straight_ready", 64'(req_ready), 64'd3);
    tick();
    idle();
    tgt_resp_valid = 2'b11;
    tgt_resp_rdata = {32'h0000_5555, 32'hAAAA_0000};
    push_resp(1'b0, 32'hAAAA_0000);
    push_resp(1'b1, 32'h0000_5555);
    tick();
    idle();
    tick();

    // Crossed: req0->bank1 (write), req1->bank0.
    req_valid = 2'b11; req_tgt = 2'b01; req_we = 2'b01; tgt_ready = 2'b11;
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    req_wdata = {32'h0000_1234, 32'hCAFE_0001};
    push_acc(1'b0, 1'b1, 1'b0, 32'h200, 32'h1234, 1'b1);
    push_acc(1'b1, 1'b0, 1'b1, 32'h100, 32'hCAFE_0001, 1'b1);
    settle();
    chk("crossed_swap", 64'(xbar_swap), 64'd1);
    chk("crossed_addr1", 64'(tgt_addr[1]), 64'h100);
    tick();
    idle();
    tgt_resp_valid = 2'b11;
    tgt_resp_rdata = {32'h0000_1B1B, 32'h0000_0B0B};
    push_resp(1'b0, 32'h0000_1B1B);
    push_resp(1'b1, 32'h0000_0B0B);
    tick();
    idle();
    tick();

    // Contention on bank0: 4 transactions each, grants alternate 0,1,0,1...
    begin
      int n0, n1;
      n0 = 0; n1 = 0;
      for (int k = 0; k < 8; k++) begin
        logic w;
        w = k[0];
        idle();
        req_valid = 2'b11; req_tgt = 2'b00; tgt_ready = 2'b01;
        req_addr  = {32'h310 + 32'(n1), 32'h300 + 32'(n0)};
        push_acc(1'b0, w, 1'b0, w ? 32'h310 + 32'(n1) : 32'h300 + 32'(n0), 32'h0, w);
        settle();
        chk("contend_ready", 64'(req_ready), w ? 64'd2 : 64'd1);
        if (w) n1++; else n0++;
        tick();
        req_addr       = {32'h310 + 32'(n1), 32'h300 + 32'(n0)};
        tgt_ready      = 2'b00;
        tgt_resp_valid = 2'b01;
        tgt_resp_rdata = {32'h0, 32'hC000 + 32'(k)};
        push_resp(w, 32'hC000 + 32'(k));
        settle();
        chk("contend_busy_tgt_valid", 64'(tgt_valid), 64'd0);
        tick();
      end
      idle();
      tick();
    end

    // Busy bank: bank0 withholds its response; req1 waits, no same-cycle re-grant.
    req_valid = 2'b01; req_tgt = 2'b00; tgt_ready = 2'b01;
    req_addr  = {32'h0, 32'h400};
    push_acc(1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0);
    tick();
    req_valid = 2'b10; req_addr = {32'h500, 32'h0};
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("busy_hold", 64'({tgt_valid, req_ready}), 64'd0);
      tick();
    end
    tgt_resp_valid = 2'b01; tgt_resp_rdata = {32'h0, 32'hD00D};
    push_resp(1'b0, 32'hD00D);
    settle();
    chk("busy_no_bypass", 64'({tgt_valid, req_ready}), 64'd0);
    tick();
    tgt_resp_valid = 2'b00;
    push_acc(1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b1);
    settle();
    chk("busy_next_grant", 64'(req_ready), 64'd2);
    tick();
    idle();
    tgt_resp_valid = 2'b01; tgt_resp_rdata = {32'h0, 32'hE00E};
    push_resp(1'b1, 32'hE00E);
    tick();
    idle();
    tick();

    // Backpressure on bank1 for 3 cycles, accepted on the 4th.
    req_valid = 2'b10; req_tgt = 2'b10; req_addr = {32'h600, 32'h0};
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("bp_hold", 64'({tgt_valid, req_ready}), 64'b1000);
      chk("bp_addr", 64'(tgt_addr[1]), 64'h600);
      tick();
    end
    tgt_ready = 2'b10;
    push_acc(1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 1'b0);
    tick();
    idle();
    tgt_resp_valid = 2'b10; tgt_resp_rdata = {32'hF00F, 32'h0};
    push_resp(1'b1, 32'hF00F);
    tick();
    idle();
    tick();

    // Reset while bank1 is busy (owned by req0), then a stray response.
    req_valid = 2'b01; req_tgt = 2'b01; tgt_ready = 2'b10; req_addr = {32'h0, 32'h700};
    push_acc(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 1'b1);
    tick();
    idle();
    rst_n = 1'b0;
    settle();
    chk("midreset_ctrl", 64'({req_ready, resp_valid, tgt_valid, xbar_swap}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tgt_resp_valid = 2'b10; tgt_resp_rdata = {32'h0BAD_0BAD, 32'h0};
    settle();
    chk("stray_resp", 64'(resp_valid), 64'd0);
    tick();
    idle();
    req_valid = 2'b11; req_tgt = 2'b11; tgt_ready = 2'b10;
    req_addr  = {32'h900, 32'h800};
    push_acc(1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 1'b1);
    settle();
    chk("post_reset_rr", 64'(req_ready), 64'd1);
    tick();
    idle();
    tgt_resp_valid = 2'b10; tgt_resp_rdata = {32'h7777, 32'h0};
    push_resp(1'b0, 32'h7777);
    tick();
    idle();
    tick();
    @(negedge clk);
    #1;
    chk("acc_queue_empty", 64'(exp_acc.size()), 64'd0);
    chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
